// File: rtl/stack_unit.sv
// Stack-op sequencer: accepts one PUSH/POP/CALL/RET at a time, runs the
// data-memory access, then issues SP adjust / writeback / PC redirect in one commit cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | op_ready high, legality checked and operands latched on accept
// S_REQ    | mem_req held until mem_ack or TIMEOUT cycles have elapsed
// S_COMMIT | single-cycle pulse of side effects, or of the fault code
module stack_unit #(
  parameter logic [31:0] STACK_TOP   = 32'h0000_1000,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0800,
  parameter int          TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [4:0]  op_rd,
  input  logic [31:0] op_data,
  input  logic [31:0] op_target,
  input  logic [31:0] sp_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  stack_op,
  output logic        wb_write,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        pc_load,
  output logic [31:0] pc_value,
  output logic [1:0]  fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_REQ    = 2'b01,
    S_COMMIT = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_code;
  logic [4:0]      r_rd;
  logic [31:0]     r_data;
  logic [31:0]     r_target;
  logic [31:0]     r_addr;
  logic [31:0]     r_rdata;
  logic [1:0]      r_fault;
  logic [CW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_push_like;
  logic [31:0]     w_sp_dec;
  logic [31:0]     w_addr_acc;
  logic [1:0]      w_fault_acc;
  logic            w_timeout;
  logic            w_r_write;

  // PUSH and CALL both write memory (op_code[0] == 0).
  assign w_accept    = op_valid && (r_state == S_IDLE);
  assign w_push_like = ~op_code[0];
  assign w_sp_dec    = sp_in - 32'd4;
  assign w_addr_acc  = w_push_like ? w_sp_dec : sp_in;
  assign w_timeout   = (r_cnt == CW'(TIMEOUT - 1));
  assign w_r_write   = ~r_code[0];

  always_comb begin
    w_fault_acc = 2'b00;
    if (w_push_like) begin
      if (w_sp_dec < STACK_LIMIT) w_fault_acc = 2'b01;
    end else if ((sp_in >= STACK_TOP) || ((op_code == OP_POP) && (op_rd == 5'd29))) begin
      w_fault_acc = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = (w_fault_acc != 2'b00) ? S_COMMIT : S_REQ;
      S_REQ:    if (mem_ack || w_timeout) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_code   <= 2'b00;
      r_rd     <= 5'd0;
      r_data   <= 32'd0;
      r_target <= 32'd0;
      r_addr   <= 32'd0;
      r_rdata  <= 32'd0;
      r_fault  <= 2'b00;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_code   <= op_code;
          r_rd     <= op_rd;
          r_data   <= op_data;
          r_target <= op_target;
          r_addr   <= w_addr_acc;
          r_rdata  <= 32'd0;
          r_fault  <= w_fault_acc;
          r_cnt    <= '0;
        end
        S_REQ: begin
          // An ack in the last allowed cycle still wins over the timeout.
          if (mem_ack)        r_rdata <= mem_rdata;
          else if (w_timeout) r_fault <= 2'b11;
          else                r_cnt   <= r_cnt + CW'(1);
        end
        S_COMMIT: begin
          r_fault <= 2'b00;
          r_cnt   <= '0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    op_ready  = (r_state == S_IDLE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    stack_op  = 2'b00;
    wb_write  = 1'b0;
    wb_reg    = 5'd0;
    wb_data   = 32'd0;
    pc_load   = 1'b0;
    pc_value  = 32'd0;
    fault     = 2'b00;
    if (r_state == S_REQ) begin
      mem_req   = 1'b1;
      mem_we    = w_r_write;
      mem_addr  = r_addr;
      mem_wdata = w_r_write ? r_data : 32'd0;
    end else if (r_state == S_COMMIT) begin
      if (r_fault != 2'b00) begin
        fault = r_fault;
      end else begin
        case (r_code)
          OP_PUSH: stack_op = 2'b10;
          OP_CALL: begin
            stack_op = 2'b10;
            pc_load  = 1'b1;
            pc_value = r_target;
          end
          OP_POP: begin
            stack_op = 2'b01;
            if (r_rd != 5'd0) begin
              wb_write = 1'b1;
              wb_reg   = r_rd;
              wb_data  = r_rdata;
            end
          end
          OP_RET: begin
            stack_op = 2'b01;
            pc_load  = 1'b1;
            pc_value = r_rdata;
          end
          default: stack_op = 2'b00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a stack/memory model predicts each op's
// memory access and commit pulses; a negedge monitor compares what the DUT presents.
module tb_stack_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_ready;
  logic [1:0]  op_code;
  logic [4:0]  op_rd;
  logic [31:0] op_data, op_target, sp_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [1:0]  stack_op;
  logic        wb_write;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        pc_load;
  logic [31:0] pc_value;
  logic [1:0]  fault;

  always #5 clk = ~clk;

  stack_unit dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_rd(op_rd), .op_data(op_data), .op_target(op_target),
    .sp_in(sp_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stack_op(stack_op), .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .pc_load(pc_load), .pc_value(pc_value), .fault(fault)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;

  typedef struct {
    logic [1:0]  stack_op;
    logic        wb_write;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        pc_load;
    logic [31:0] pc_value;
    logic [1:0]  fault;
    int          req_len;
  } cmt_t;

  mem_t        mem_q[$];
  cmt_t        cmt_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] sp_m;
  logic [31:0] mem_m [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    int   req_cnt;
    logic rdy_pending;
    mem_t first;
    cmt_t c;
    req_cnt = 0;
    rdy_pending = 1'b0;
    first = '{we: 1'b0, addr: 32'd0, wdata: 32'd0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        req_cnt = 0;
        rdy_pending = 1'b0;
      end else begin
        if (rdy_pending) begin
          chk("ready_after_commit", {31'd0, op_ready}, 32'd1);
          rdy_pending = 1'b0;
        end
        if (mem_req) begin
          chk("ready_low_in_req", {31'd0, op_ready}, 32'd0);
          if (req_cnt == 0) begin
            if (mem_q.size() == 0) begin
              chk("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
              first = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
            end else begin
              first = mem_q.pop_front();
              chk("mem_we", {31'd0, mem_we}, {31'd0, first.we});
              chk("mem_addr", mem_addr, first.addr);
              if (first.we) chk("mem_wdata", mem_wdata, first.wdata);
            end
          end else begin
            chk("mem_addr_stable", mem_addr, first.addr);
          end
          req_cnt++;
        end else begin
          chk("mem_addr_zero_idle", mem_addr, 32'd0);
        end
        if (stack_op != 2'b00 || wb_write || pc_load || fault != 2'b00) begin
          if (cmt_q.size() == 0) begin
            chk("unexpected_commit", {30'd0, stack_op} | {30'd0, fault}, 32'd0);
          end else begin
            c = cmt_q.pop_front();
            chk("stack_op", {30'd0, stack_op}, {30'd0, c.stack_op});
            chk("wb_write", {31'd0, wb_write}, {31'd0, c.wb_write});
            if (c.wb_write) begin
              chk("wb_reg", {27'd0, wb_reg}, {27'd0, c.wb_reg});
              chk("wb_data", wb_data, c.wb_data);
            end
            chk("pc_load", {31'd0, pc_load}, {31'd0, c.pc_load});
            if (c.pc_load) chk("pc_value", pc_value, c.pc_value);
            chk("fault", {30'd0, fault}, {30'd0, c.fault});
            chk("req_cycles", req_cnt, c.req_len);
            chk("ready_low_in_commit", {31'd0, op_ready}, 32'd0);
            rdy_pending = 1'b1;
          end
          req_cnt = 0;
        end
      end
    end
  end

  // Issue one op; d = ack in REQ cycle d+1, d >= 16 means no ack ever.
  task automatic do_op(input logic [1:0] code, input logic [4:0] rd, input logic [31:0] data,
                       input logic [31:0] tgt, input logic [31:0] sp, input int d,
                       input logic [31:0] rdata);
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  f;
    bit          acc;
    cmt_t        c;
    int          n;
    wr   = (code == 2'b00) || (code == 2'b10);
    addr = wr ? sp - 32'd4 : sp;
    f    = 2'b00;
    if (wr && addr < 32'h0000_0800) f = 2'b01;
    else if (!wr && (sp >= 32'h0000_1000 || (code == 2'b01 && rd == 5'd29))) f = 2'b10;
    acc = (f == 2'b00);
    if (acc && d >= 16) f = 2'b11;
    if (acc) mem_q.push_back('{we: wr, addr: addr, wdata: wr ? data : 32'd0});
    c = '{stack_op: 2'b00, wb_write: 1'b0, wb_reg: 5'd0, wb_data: 32'd0,
          pc_load: 1'b0, pc_value: 32'd0, fault: f, req_len: 0};
    c.req_len = !acc ? 0 : (d >= 16 ? 16 : d + 1);
    if (f == 2'b00) begin
      case (code)
        2'b00: c.stack_op = 2'b10;
        2'b10: begin c.stack_op = 2'b10; c.pc_load = 1'b1; c.pc_value = tgt; end
        2'b01: begin
          c.stack_op = 2'b01;
          c.wb_write = (rd != 5'd0);
          c.wb_reg   = rd;
          c.wb_data  = rdata;
        end
        default: begin c.stack_op = 2'b01; c.pc_load = 1'b1; c.pc_value = rdata; end
      endcase
    end
    cmt_q.push_back(c);

    n = 0;
    while (!op_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!op_ready) chk("wait_op_ready", {31'd0, op_ready}, 32'd1);
    op_valid = 1'b1; op_code = code; op_rd = rd; op_data = data; op_target = tgt; sp_in = sp;
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (acc && d < 16) begin
      for (int i = 0; i < d; i++) begin
        op_valid = 1'($urandom_range(0, 1));
        op_code  = 2'($urandom_range(0, 3));
        op_data  = $urandom;
        sp_in    = $urandom;
        @(posedge clk); #1;
      end
      op_valid  = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
    n = 0;
    while (cmt_q.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
    if (cmt_q.size() != 0) begin
      chk("commit_timeout", cmt_q.size(), 32'd0);
      cmt_q.delete();
      mem_q.delete();
    end
    @(posedge clk); #1;
    if (f == 2'b00) begin
      if (wr) begin mem_m[addr] = data; sp_m = addr; end
      else sp_m = sp + 32'd4;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] sp, rdata;
    logic [1:0]  code;
    logic [4:0]  rd;
    int          d;
    reset = 1'b0; op_valid = 1'b0; op_code = 2'b00; op_rd = 5'd0; op_data = 32'd0;
    op_target = 32'd0; sp_in = 32'h1000; mem_rdata = 32'd0; mem_ack = 1'b0;
    sp_m = 32'h0000_1000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_stack_op", {30'd0, stack_op}, 32'd0);
    chk("rst_pulses", {29'd0, wb_write, pc_load, 1'b0} | {30'd0, fault}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    do_op(2'b00, 5'd0,  32'hDEAD_BEEF, 32'd0,     32'h1000, 1,  32'd0);
    do_op(2'b01, 5'd5,  32'd0,         32'd0,     32'h0FFC, 0,  32'h1234);
    do_op(2'b01, 5'd0,  32'd0,         32'd0,     32'h0FFC, 2,  32'h5555);
    do_op(2'b01, 5'd29, 32'd0,         32'd0,     32'h0FFC, 0,  32'h1);
    do_op(2'b01, 5'd7,  32'd0,         32'd0,     32'h1000, 0,  32'h1);
    do_op(2'b10, 5'd0,  32'h44,        32'h200,   32'h0F00, 0,  32'd0);
    do_op(2'b11, 5'd0,  32'd0,         32'd0,     32'h0EFC, 3,  32'h44);
    do_op(2'b00, 5'd0,  32'hABCD,      32'd0,     32'h0F00, 99, 32'd0);
    do_op(2'b00, 5'd0,  32'h1,         32'd0,     32'h0800, 0,  32'd0);
    do_op(2'b00, 5'd0,  32'h77,        32'd0,     32'h0804, 0,  32'd0);
    do_op(2'b11, 5'd0,  32'd0,         32'd0,     32'h0FFC, 15, 32'hCAFE);

    // Reset while the memory request is outstanding, then a late ack.
    mem_q.push_back('{we: 1'b1, addr: 32'h0FFC, wdata: 32'h9999});
    op_valid = 1'b1; op_code = 2'b00; op_rd = 5'd0; op_data = 32'h9999; sp_in = 32'h1000;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_mid_stack_op", {30'd0, stack_op}, 32'd0);
    chk("rst_mid_fault", {30'd0, fault}, 32'd0);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_mid_mem_q_drained", mem_q.size(), 32'd0);

    sp_m = 32'h0000_1000;
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 9))
        0:       sp = 32'h0000_1000;
        1:       sp = 32'h0000_0800;
        2:       sp = 32'h0000_0804;
        3:       sp = $urandom;
        default: sp = sp_m;
      endcase
      code = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rd = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd29;
      else rd = 5'($urandom_range(0, 31));
      d = ($urandom_range(0, 9) == 0) ? 16 + $urandom_range(0, 3) : $urandom_range(0, 15);
      rdata = mem_m.exists(sp) ? mem_m[sp] : $urandom;
      do_op(code, rd, $urandom, $urandom, sp, d, rdata);
      if ($urandom_range(0, 4) == 0) begin
        mem_ack = 1'b1; mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
      end
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("final_mem_q_empty", mem_q.size(), 32'd0);
    chk("final_cmt_q_empty", cmt_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Sequencer for stack instructions (PUSH, POP, CALL, RET). Sits directly upstream of the register bank.
- Takes one decoded stack op at a time over a valid/ready handshake and runs the data-memory access with a req/ack handshake.
- In one commit cycle, drives the register bank's stack-pointer adjust (stack_op), register writeback, and a PC redirect.
- The SP value comes from the register bank's SP output (register 29).

Parameters:
- STACK_TOP, 32'h0000_1000, empty-stack SP value; POP/RET with sp_in >= STACK_TOP is an underflow.
- STACK_LIMIT, 32'h0000_0800, lowest legal stack word address; PUSH/CALL with sp_in - 4 < STACK_LIMIT is an overflow.
- TIMEOUT, 16, maximum cycles mem_req may wait for mem_ack before the op is aborted.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset (reset==0 clears state at posedge clk).
- op_valid  in  1  stack op request.
- op_ready  out  1  unit can accept an op (high only in IDLE).
- op_code  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET.
- op_rd  in  5  POP destination register.
- op_data  in  32  PUSH value / CALL return address.
- op_target  in  32  CALL target PC.
- sp_in  in  32  current SP from register bank.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = write (PUSH/CALL), 0 = read.
- mem_addr  out  32  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion.
- stack_op  out  2  to register bank: 01 = SP+4, 10 = SP-4, 00 = none.
- wb_write  out  1  register writeback strobe.
- wb_reg  out  5  writeback register address.
- wb_data  out  32  writeback data.
- pc_load  out  1  PC redirect strobe.
- pc_value  out  32  redirect PC.
- fault  out  2  one-cycle pulse code: 00 none, 01 overflow, 10 underflow/illegal, 11 timeout.

Behaviour:
- Reset: state IDLE, op_ready=1, all other outputs 0, timeout counter 0.
- Reset takes priority over everything. If asserted mid-op, mem_req drops next cycle, no stack_op/wb/pc pulse is issued, and any late mem_ack is ignored.
- FSM states: IDLE, REQ, COMMIT.
- IDLE: on op_valid && op_ready (cycle 0), latch op_code, op_rd, op_data, op_target and sp_in.
  - Address: PUSH/CALL use sp_in - 4; POP/RET use sp_in. Arithmetic is 32-bit unsigned, wrap ignored.
  - Legality checks run at accept:
    - overflow (PUSH/CALL with sp_in - 4 < STACK_LIMIT);
    - underflow (POP/RET with sp_in >= STACK_TOP);
    - illegal (POP with op_rd == 29).
  - Illegal op: go directly to COMMIT with fault latched; no memory access.
  - Legal op: go to REQ.
- REQ: mem_req=1 with mem_we, mem_addr, mem_wdata held stable.
  - Counter increments each REQ cycle.
  - mem_ack sampled high -> latch mem_rdata, go to COMMIT.
  - Counter reaches TIMEOUT without ack -> fault=11, go to COMMIT with no side effects.
  - mem_req is registered: high from cycle 1 and low in the cycle after ack.
- COMMIT (exactly one cycle): pulses fire only if no fault.
  - PUSH: stack_op=10.
  - CALL: stack_op=10, pc_load=1, pc_value=op_target.
  - POP: stack_op=01; wb_write=1 only if op_rd != 0; wb_reg=op_rd; wb_data=rdata.
  - RET: stack_op=01, pc_load=1, pc_value=rdata.
  - On fault: all of the above stay 0 and the fault code pulses.
  - Next state is IDLE.
- Latency: ack sampled in cycle k gives COMMIT in k+1 and op_ready again in k+2. The SP update lands at the end of k+1, so the next op sees the updated sp_in.
- op_ready=0 in REQ and COMMIT. op_valid during those states is ignored and not queued.
- mem_ack in IDLE or COMMIT is ignored.
- Outputs not being pulsed hold 0; mem_addr/mem_wdata are 0 outside REQ.

Test Plan:
- PUSH: sp_in=0x1000, op_data=0xDEADBEEF, ack after 2 cycles -> mem write addr 0xFFC data 0xDEADBEEF; one-cycle stack_op=10; op_ready back 2 cycles after ack.
- POP: sp_in=0xFFC, op_rd=5, mem_rdata=0x1234 -> read addr 0xFFC; COMMIT has stack_op=01, wb_write=1, wb_reg=5, wb_data=0x1234.
- Faults:
  - POP with op_rd=0 -> wb_write stays 0, stack_op=01.
  - POP with op_rd=29 -> fault=10, no mem_req.
  - POP at sp_in=0x1000 -> fault=10, no mem_req.
- CALL then RET: CALL op_data=0x44, op_target=0x200, sp_in=0xF00 -> write 0x44 to 0xEFC, pc_load with pc_value=0x200; RET at sp_in=0xEFC with rdata=0x44 -> pc_value=0x44, stack_op=01.
- Timeout and overflow:
  - mem_ack never asserted -> mem_req high exactly 16 cycles, then fault=11 with no stack_op/pc_load.
  - PUSH at sp_in=0x800 -> fault=01 with no mem_req.
- Reset mid-REQ: reset=0 during mem_req -> next cycle mem_req=0, op_ready=1, no pulses; a late mem_ack produces no COMMIT.
